reg_access_arbiter: RTL and testbench
=====================================

# reg_access_arbiter

Controller that shares the single register-agent bus (addr/wr/wr_data/rd/rd_data/int_n) between several on-chip requesters, e.g. the configuration sequencer and the rx-packet service logic. It accepts one read or write transaction at a time per requester and arbitrates round-robin, with interrupt-driven priority for one designated requester. It generates single-cycle bus strobes, waits a fixed read latency, and returns a response to the originating requester.

## Interface
- N_REQ, default 2: number of requesters (2..4).
- ADDR_W, default 3: register address width.
- DATA_W, default 8: register data width.
- RD_LATENCY, default 1: cycles from the rd strobe cycle to the cycle in which rd_data is valid (0..3).
- IRQ_REQ, default 0: index of the requester that gets priority while the interrupt is pending.

- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  N_REQ  per-requester transaction request; held until accepted.
- req_write  input  N_REQ  1 = write, 0 = read.
- req_addr  input  N_REQ*ADDR_W  per-requester address; slice i belongs to requester i.
- req_wdata  input  N_REQ*DATA_W  per-requester write data.
- req_ready  output  N_REQ  one-hot accept for the current cycle.
- rsp_valid  output  N_REQ  one-hot, single-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data, valid with rsp_valid (0 for writes).
- addr  output  ADDR_W  register bus address.
- wr  output  1  write strobe.
- wr_data  output  DATA_W  write data.
- rd  output  1  read strobe.
- rd_data  input  DATA_W  read data from the register block.
- int_n  input  1  active-low rx-packet-available interrupt.
- irq  output  1  registered, active-high copy of the interrupt.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - WR: wr strobe.
  - RD: rd strobe.
  - WAIT: count the read latency.
  - RESP: respond.
- IDLE: if any req_valid is high, select a winner and assert req_ready[winner] combinationally in the same cycle.
  - Latch the winner's write flag, address, wdata and index.
  - Next state is WR or RD.
- Arbitration is round-robin.
  - Search starts at (last_grant+1) mod N_REQ.
  - last_grant resets to N_REQ-1, so requester 0 wins first.
- Override: if irq=1 and req_valid[IRQ_REQ]=1, IRQ_REQ wins. last_grant still updates to IRQ_REQ.
- WR: wr=1 for exactly one cycle with addr and wr_data driven; next state RESP.
- RD: rd=1 for exactly one cycle with addr driven.
  - If RD_LATENCY=0, capture rd_data this cycle and go to RESP.
  - Otherwise go to WAIT.
- WAIT: down-counter, 2 bits, loaded with RD_LATENCY-1. At count 0, capture rd_data and go to RESP.
- RESP: rsp_valid[index]=1 for one cycle, rsp_rdata = captured data (0 for writes). Next state IDLE.
- Only one transaction is outstanding at a time. req_ready is 0 in every state other than IDLE.
- addr and wr_data hold their last values between transactions. wr and rd are 0 outside WR and RD.
- irq <= ~int_n every cycle.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, addr=0, wr=0, wr_data=0, rd=0, irq=0. State IDLE, last_grant=N_REQ-1, counter 0.
- Accept in cycle T. Write: wr=1 in T+1, rsp_valid in T+2, next accept possible in T+3.
- Read: rd=1 in T+1, rd_data sampled in T+1+RD_LATENCY, rsp_valid in T+2+RD_LATENCY.
- irq follows int_n with one cycle of latency. The override uses the registered irq, not int_n directly.
- A requester may drop req_valid only after its req_ready. Changing addr or data while waiting for ready is legal; the values present at accept are used.
- Simultaneous requests: exactly one req_ready per cycle. Losers keep req_valid high and are served in subsequent IDLE cycles.
- rst during WR, RD, WAIT or RESP: the transaction is aborted with no rsp_valid. Strobes are 0 from the next cycle and the next grant goes to requester 0.
- A requester may re-assert req_valid in the cycle it receives rsp_valid. Accept happens no earlier than the next IDLE cycle.

## Test plan
- Reset: assert rst 2 cycles with all inputs toggling -> every output 0; the first later request from requester 1 alone is granted.
- Write: req0 write, addr=3, wdata=0xA5, accepted at T -> wr=1, addr=3, wr_data=0xA5 in T+1 only; rsp_valid=01 in T+2 with rsp_rdata=0.
- Read, RD_LATENCY=1: req1 read addr=5, bus model returns 0x3C in the cycle after rd -> rd=1 in T+1; rsp_valid=10 with rsp_rdata=0x3C in T+3.
- Round-robin: req0 and req1 both hold continuous write requests -> grants alternate 0,1,0,1 and requester 0 is first after reset; exactly one req_ready per cycle.
- Interrupt priority: int_n=0 with both requesting and last_grant=0 -> irq=1 one cycle later, then requester 0 (IRQ_REQ) is granted again; after int_n=1 the alternation resumes.
- Reset mid-read: rst pulsed during WAIT (RD_LATENCY=2) -> no rsp_valid, rd=0; the next grant goes to requester 0 and completes normally.

Source files
------------

// File: rtl/reg_access_arbiter_if.sv
// Requester and register-bus signal bundle for reg_access_arbiter.
// No logic. The slave modport is the arbiter's view; master is the driver side.
// Every signal is sized from N_REQ/ADDR_W/DATA_W, which must match the arbiter instance.
interface reg_access_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_write;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_ready;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_rdata;
   logic [ADDR_W-1:0]       addr;
   logic                    wr;
   logic [DATA_W-1:0]       wr_data;
   logic                    rd;
   logic [DATA_W-1:0]       rd_data;
   logic                    int_n;
   logic                    irq;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rd_data, int_n,
      output req_ready, rsp_valid, rsp_rdata, addr, wr, wr_data, rd, irq
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rd_data, int_n,
      input  req_ready, rsp_valid, rsp_rdata, addr, wr, wr_data, rd, irq
   );
endinterface

// File: rtl/reg_access_arbiter.sv
// Shares one register bus between N_REQ requesters: round-robin arbitration with an irq override.
// Latency: write response 2 cycles after accept, read response 2+RD_LATENCY cycles after accept.
// Backpressure: one transaction outstanding; req_ready only pulses in IDLE, and losers hold req_valid.
module reg_access_arbiter #(
   parameter int N_REQ      = 2,
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1,
   parameter int IRQ_REQ    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   reg_access_arbiter_if.slave  bus_io
);
   localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                irq_q;

   logic [IDX_W-1:0]    win;
   logic [IDX_W-1:0]    cand;
   logic                found;
   logic                grant;

   // Winner: first valid requester after last_grant, unless the pending irq favours IRQ_REQ.
   always_comb begin
      win   = last_q;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(last_q) + k) % N_REQ);
         if (!found && bus_io.req_valid[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
      if (irq_q && bus_io.req_valid[IRQ_REQ]) begin
         win = IDX_W'(IRQ_REQ);
      end
      // Reset wins over a same-cycle accept so nothing is granted while rst is high.
      grant = (state_q == S_IDLE) && found && !rst;
   end

   // Next-state and transaction capture.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      idx_d   = idx_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant) begin
               last_d  = win;
               idx_d   = win;
               write_d = bus_io.req_write[win];
               addr_d  = bus_io.req_addr[int'(win)*ADDR_W +: ADDR_W];
               wdata_d = bus_io.req_wdata[int'(win)*DATA_W +: DATA_W];
               state_d = bus_io.req_write[win] ? S_WR : S_RD;
            end
         end
         S_WR: state_d = S_RESP;
         S_RD: begin
            if (RD_LATENCY == 0) begin
               rdata_d = bus_io.rd_data;
               state_d = S_RESP;
            end else begin
               cnt_d   = 2'(RD_LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 2'd0) begin
               rdata_d = bus_io.rd_data;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode; strobes and responses are suppressed during reset so an abort never completes.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         bus_io.req_ready[i] = grant && (win == IDX_W'(i));
         bus_io.rsp_valid[i] = !rst && (state_q == S_RESP) && (idx_q == IDX_W'(i));
      end
      bus_io.rsp_rdata = (!rst && (state_q == S_RESP) && !write_q) ? rdata_q : '0;
      bus_io.wr        = !rst && (state_q == S_WR);
      bus_io.rd        = !rst && (state_q == S_RD);
      bus_io.addr      = addr_q;
      bus_io.wr_data   = wdata_q;
      bus_io.irq       = irq_q;
   end

   // State register, transaction latches and the registered interrupt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= IDX_W'(N_REQ - 1);
         idx_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         irq_q   <= ~bus_io.int_n;
      end
   end
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: one instance with RD_LATENCY=1, one with RD_LATENCY=2.
// Inputs change 1ns after posedge; outputs are compared 1ns later, mid-cycle.
module tb_reg_access_arbiter;
   logic clk;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   reg_access_arbiter_if #(.N_REQ(2), .ADDR_W(3), .DATA_W(8)) b1 ();
   reg_access_arbiter_if #(.N_REQ(2), .ADDR_W(3), .DATA_W(8)) b2 ();

   reg_access_arbiter #(.N_REQ(2), .ADDR_W(3), .DATA_W(8), .RD_LATENCY(1), .IRQ_REQ(0)) dut1 (
      .clk(clk), .rst(rst), .bus_io(b1));
   reg_access_arbiter #(.N_REQ(2), .ADDR_W(3), .DATA_W(8), .RD_LATENCY(2), .IRQ_REQ(0)) dut2 (
      .clk(clk), .rst(rst), .bus_io(b2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv1(input logic [1:0] v, input logic [1:0] w, input logic [2:0] a0,
                       input logic [2:0] a1, input logic [7:0] d0, input logic [7:0] d1);
      b1.req_valid = v;
      b1.req_write = w;
      b1.req_addr  = {a1, a0};
      b1.req_wdata = {d1, d0};
   endtask

   function automatic logic [31:0] outs1();
      return {6'd0, b1.req_ready, b1.rsp_valid, b1.rsp_rdata, b1.addr, b1.wr, b1.wr_data, b1.rd, b1.irq};
   endfunction

   function automatic logic [31:0] outs2();
      return {6'd0, b2.req_ready, b2.rsp_valid, b2.rsp_rdata, b2.addr, b2.wr, b2.wr_data, b2.rd, b2.irq};
   endfunction

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      drv1(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      b1.int_n = 1'b1; b1.rd_data = 8'h00;
      b2.req_valid = 2'b00; b2.req_write = 2'b00; b2.req_addr = '0; b2.req_wdata = '0;
      b2.int_n = 1'b1; b2.rd_data = 8'h00;

      // Reset held two cycles with inputs toggling: every output stays 0.
      tick();
      drv1(2'b11, 2'b11, 3'd7, 3'd6, 8'hFF, 8'hEE);
      b1.int_n = 1'b0; b1.rd_data = 8'hFF;
      b2.req_valid = 2'b11; b2.int_n = 1'b0; b2.req_write = 2'b01;
      #1;
      chk("rst_outs1_c1", outs1(), 32'd0);
      chk("rst_outs2_c1", outs2(), 32'd0);
      tick();
      drv1(2'b01, 2'b10, 3'd1, 3'd2, 8'h55, 8'hAA);
      b1.int_n = 1'b1; b1.rd_data = 8'h0F;
      b2.req_valid = 2'b10; b2.int_n = 1'b1;
      #1;
      chk("rst_outs1_c2", outs1(), 32'd0);
      chk("rst_outs2_c2", outs2(), 32'd0);

      // Release reset; requester 1 alone writes addr 2 / 0x11.
      tick();
      rst = 1'b0;
      drv1(2'b10, 2'b10, 3'd0, 3'd2, 8'h00, 8'h11);
      b1.int_n = 1'b1; b1.rd_data = 8'h00;
      b2.req_valid = 2'b00; b2.req_write = 2'b00; b2.int_n = 1'b1;
      #1;
      chk("first_grant_req1", b1.req_ready, 2'b10);
      chk("irq_idle", b1.irq, 1'b0);
      tick();
      drv1(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      #1;
      chk("r1_wr_strobe", {b1.wr, b1.rd, b1.addr, b1.wr_data}, {1'b1, 1'b0, 3'd2, 8'h11});
      tick();
      #1;
      chk("r1_rsp", {b1.rsp_valid, b1.rsp_rdata, b1.wr}, {2'b10, 8'h00, 1'b0});

      // Write: req0 addr 3 data A5.
      tick();
      drv1(2'b01, 2'b01, 3'd3, 3'd7, 8'hA5, 8'h5A);
      #1;
      chk("wr_accept", b1.req_ready, 2'b01);
      chk("wr_no_strobe_T", {b1.wr, b1.rd}, 2'b00);
      tick();
      drv1(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      #1;
      chk("wr_strobe_T1", {b1.wr, b1.rd, b1.addr, b1.wr_data, b1.req_ready}, {1'b1, 1'b0, 3'd3, 8'hA5, 2'b00});
      tick();
      #1;
      chk("wr_rsp_T2", {b1.rsp_valid, b1.rsp_rdata, b1.wr}, {2'b01, 8'h00, 1'b0});
      tick();
      #1;
      chk("wr_idle_T3", {b1.rsp_valid, b1.addr, b1.wr_data}, {2'b00, 3'd3, 8'hA5});

      // Read, RD_LATENCY=1: req1 addr 5, bus returns 3C the cycle after rd.
      drv1(2'b10, 2'b00, 3'd1, 3'd5, 8'h00, 8'h00);
      b1.rd_data = 8'hEE;
      #1;
      chk("rd_accept", b1.req_ready, 2'b10);
      tick();
      drv1(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      #1;
      chk("rd_strobe_T1", {b1.rd, b1.wr, b1.addr}, {1'b1, 1'b0, 3'd5});
      tick();
      b1.rd_data = 8'h3C;
      #1;
      chk("rd_wait_T2", {b1.rd, b1.rsp_valid}, {1'b0, 2'b00});
      tick();
      b1.rd_data = 8'h77;
      #1;
      chk("rd_rsp_T3", {b1.rsp_valid, b1.rsp_rdata}, {2'b10, 8'h3C});
      tick();
      #1;
      chk("rd_rsp_done", {b1.rsp_valid, b1.rsp_rdata}, {2'b00, 8'h00});

      // Round-robin: both hold writes; grants alternate 0,1,0,1, one ready per cycle.
      drv1(2'b11, 2'b11, 3'd4, 3'd6, 8'h40, 8'h60);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_grant", b1.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         #1;
         chk("rr_wr_no_ready", {b1.req_ready, b1.wr, b1.addr}, {2'b00, 1'b1, (i % 2 == 0) ? 3'd4 : 3'd6});
         tick();
         #1;
         chk("rr_rsp", {b1.req_ready, b1.rsp_valid}, {2'b00, (i % 2 == 0) ? 2'b01 : 2'b10});
         tick();
      end

      // Interrupt priority: make last_grant=0, then irq holds requester 0 ahead of round-robin.
      drv1(2'b01, 2'b01, 3'd4, 3'd0, 8'h44, 8'h00);
      #1;
      chk("irq_pre_grant", b1.req_ready, 2'b01);
      tick();
      drv1(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      b1.int_n = 1'b0;
      #1;
      chk("irq_lag", b1.irq, 1'b0);
      tick();
      #1;
      chk("irq_set", b1.irq, 1'b1);
      tick();
      drv1(2'b11, 2'b11, 3'd1, 3'd2, 8'h10, 8'h20);
      #1;
      chk("irq_ovr1", {b1.irq, b1.req_ready}, {1'b1, 2'b01});
      tick();
      #1;
      chk("irq_ovr1_wr", {b1.wr, b1.addr, b1.wr_data}, {1'b1, 3'd1, 8'h10});
      tick();
      tick();
      #1;
      chk("irq_ovr2", b1.req_ready, 2'b01);
      tick();
      tick();
      b1.int_n = 1'b1;
      tick();
      #1;
      chk("rr_resume", {b1.irq, b1.req_ready}, {1'b0, 2'b10});
      tick();
      drv1(2'b00, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00);
      #1;
      chk("rr_resume_wr", {b1.wr, b1.addr, b1.wr_data}, {1'b1, 3'd2, 8'h20});
      tick();
      #1;
      chk("rr_resume_rsp", b1.rsp_valid, 2'b10);
      tick();

      // Reset mid-read on the RD_LATENCY=2 instance.
      b2.req_valid = 2'b01; b2.req_write = 2'b00; b2.req_addr = {3'd0, 3'd6};
      b2.rd_data = 8'hC3;
      #1;
      chk("l2_accept", b2.req_ready, 2'b01);
      tick();
      b2.req_valid = 2'b00;
      #1;
      chk("l2_rd_strobe", {b2.rd, b2.addr}, {1'b1, 3'd6});
      tick();
      rst = 1'b1;
      #1;
      chk("l2_rst_in_wait", {b2.rd, b2.rsp_valid}, {1'b0, 2'b00});
      tick();
      rst = 1'b0;
      b2.req_valid = 2'b11; b2.req_addr = {3'd2, 3'd1};
      b2.rd_data = 8'h11;
      #1;
      chk("l2_after_rst", {b2.rd, b2.rsp_valid, b2.req_ready}, {1'b0, 2'b00, 2'b01});
      tick();
      b2.req_valid = 2'b00;
      #1;
      chk("l2_re_rd", {b2.rd, b2.addr, b2.rsp_valid}, {1'b1, 3'd1, 2'b00});
      tick();
      b2.rd_data = 8'h22;
      #1;
      chk("l2_wait1", {b2.rd, b2.rsp_valid}, {1'b0, 2'b00});
      tick();
      b2.rd_data = 8'h5A;
      #1;
      chk("l2_wait0", b2.rsp_valid, 2'b00);
      tick();
      b2.rd_data = 8'h99;
      #1;
      chk("l2_rsp", {b2.rsp_valid, b2.rsp_rdata}, {2'b01, 8'h5A});
      tick();
      #1;
      chk("l2_rsp_done", b2.rsp_valid, 2'b00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
